// File: rtl/ppi_frame_pkg.sv
// Shared constants for the PPI frame assembler: frame types, FSM encoding, checksum width.
package ppi_frame_pkg;

    localparam logic [7:0] TYPE_TIME = 8'h01;
    localparam logic [7:0] TYPE_DDS  = 8'h02;

    localparam int CRC_W = 16;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_DATA_LO = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_CRC_LO  = 3'd4;
    localparam logic [2:0] S_CRC_HI  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_LEN     = S_LEN,
        ST_DATA_LO = S_DATA_LO,
        ST_DATA_HI = S_DATA_HI,
        ST_CRC_LO  = S_CRC_LO,
        ST_CRC_HI  = S_CRC_HI
    } state_t;

    function automatic logic is_frame_type(input logic [7:0] b);
        return (b == TYPE_TIME) || (b == TYPE_DDS);
    endfunction

endpackage

// File: rtl/ppi_frame_assembler_if.sv
// Byte stream from the PPI receiver and the word stream toward DDS RAM.
interface ppi_frame_assembler_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_sof;
    logic [15:0]       ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    modport master (
        output in_data, in_valid, in_sof,
        input  ram_data, ram_addr, ram_we
    );

    modport slave (
        input  in_data, in_valid, in_sof,
        output ram_data, ram_addr, ram_we
    );
endinterface

// File: rtl/ppi_gap_timer.sv
// Counts enabled cycles since the last clear; tc fires on the TIMEOUT_CYC-th such cycle.
module ppi_gap_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + CNT_W'(1);
    end

    assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/ppi_frame_assembler.sv
// Parses TYPE/LEN/data/CRC frames from the PPI byte stream, streams DDS words to RAM
// and commits time-of-day registers only after a good checksum.
module ppi_frame_assembler
    import ppi_frame_pkg::*;
#(
    parameter int MAX_WORDS   = 250,
    parameter int TIMEOUT_CYC = 4096,
    parameter int ADDR_W      = 8
) (
    input  logic clk,
    input  logic rst,
    ppi_frame_assembler_if.slave bus,
    output logic [7:0] dni,
    output logic [7:0] h,
    output logic [7:0] min,
    output logic [7:0] s,
    output logic time_setup,
    output logic dds_update,
    output logic crc_err,
    output logic frm_err,
    output logic busy
);
    localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

    state_t state, state_next;

    logic             is_time;
    logic [7:0]       len, idx, lo_byte, crc_lo;
    logic [CRC_W-1:0] acc;
    logic [3:0][7:0]  shadow;
    logic [15:0]       ram_data_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;

    logic start, len_load, lo_load, word_take, crc_lo_load, crc_check, frm_err_next;
    logic tmo, timer_clr, timer_en;
    logic [15:0] word;

    assign word      = {bus.in_data, lo_byte};
    assign timer_en  = (state != ST_IDLE);
    assign timer_clr = bus.in_valid || (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    assign bus.ram_data = ram_data_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_we   = ram_we_q;

    ppi_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .tc  (tmo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next   = state;
        start        = 1'b0;
        len_load     = 1'b0;
        lo_load      = 1'b0;
        word_take    = 1'b0;
        crc_lo_load  = 1'b0;
        crc_check    = 1'b0;
        frm_err_next = 1'b0;

        if (bus.in_valid && bus.in_sof) begin
            // A SOF always restarts parsing; outside IDLE it also aborts the frame in flight.
            frm_err_next = (state != ST_IDLE);
            if (is_frame_type(bus.in_data)) begin
                start      = 1'b1;
                state_next = ST_LEN;
            end else begin
                frm_err_next = 1'b1;
                state_next   = ST_IDLE;
            end
        end else if (bus.in_valid) begin
            case (state)
                ST_LEN: begin
                    if (bus.in_data == 8'd0 || bus.in_data > MAX_LEN ||
                        (is_time && bus.in_data != 8'd4)) begin
                        frm_err_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        len_load   = 1'b1;
                        state_next = ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    lo_load    = 1'b1;
                    state_next = ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    word_take  = 1'b1;
                    state_next = (idx == len - 8'd1) ? ST_CRC_LO : ST_DATA_LO;
                end
                ST_CRC_LO: begin
                    crc_lo_load = 1'b1;
                    state_next  = ST_CRC_HI;
                end
                ST_CRC_HI: begin
                    crc_check  = 1'b1;
                    state_next = ST_IDLE;
                end
                default: ;
            endcase
        end else if (tmo) begin
            frm_err_next = 1'b1;
            state_next   = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_time    <= 1'b0;
            len        <= '0;
            idx        <= '0;
            lo_byte    <= '0;
            crc_lo     <= '0;
            acc        <= '0;
            shadow     <= '0;
            ram_data_q <= '0;
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            dni        <= '0;
            h          <= '0;
            min        <= '0;
            s          <= '0;
            time_setup <= 1'b0;
            dds_update <= 1'b0;
            crc_err    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            ram_we_q   <= 1'b0;
            time_setup <= 1'b0;
            dds_update <= 1'b0;
            crc_err    <= 1'b0;
            frm_err    <= frm_err_next;

            if (start) begin
                is_time <= (bus.in_data == TYPE_TIME);
                acc     <= '0;
                idx     <= '0;
            end
            if (len_load)
                len <= bus.in_data;
            if (lo_load)
                lo_byte <= bus.in_data;
            if (word_take) begin
                acc <= acc + word;
                idx <= idx + 8'd1;
                if (is_time) begin
                    shadow[3 - idx[1:0]] <= lo_byte;
                end else begin
                    ram_we_q   <= 1'b1;
                    ram_addr_q <= ADDR_W'(idx);
                    ram_data_q <= word;
                end
            end
            if (crc_lo_load)
                crc_lo <= bus.in_data;
            // Shadow time is only made visible once the whole frame has checked out.
            if (crc_check) begin
                if ({bus.in_data, crc_lo} != acc) begin
                    crc_err <= 1'b1;
                end else if (is_time) begin
                    time_setup <= 1'b1;
                    {dni, h, min, s} <= shadow;
                end else begin
                    dds_update <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppi_frame_assembler.sv
// Directed frames for ppi_frame_assembler; a frame-level model predicts per-cycle outputs.
module tb_ppi_frame_assembler;
    localparam int TIMEOUT_CYC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] dni, h, min, s;
    logic time_setup, dds_update, crc_err, frm_err, busy;

    ppi_frame_assembler_if #(.ADDR_W(8)) bus ();

    ppi_frame_assembler #(
        .MAX_WORDS   (250),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .ADDR_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dni        (dni),
        .h          (h),
        .min        (min),
        .s          (s),
        .time_setup (time_setup),
        .dds_update (dds_update),
        .crc_err    (crc_err),
        .frm_err    (frm_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, got, want);
        else
            n_pass++;
    endtask

    // Expected events keyed by the clock edge that samples the triggering byte.
    // Bits: 4 ram_we, 3 time_setup, 2 dds_update, 1 crc_err, 0 frm_err.
    logic [4:0]  exp_vec  [int];
    logic [7:0]  exp_addr [int];
    logic [15:0] exp_data [int];
    logic [31:0] exp_time [int];
    logic [31:0] m_time = '0;
    logic        chk_on = 1'b0;

    logic [15:0] ram_m [256];
    int n_we = 0, n_ts = 0, n_dds = 0, n_crc = 0, n_frm = 0;

    function automatic void post(input int c, input int b);
        logic [4:0] v;
        v = exp_vec.exists(c) ? exp_vec[c] : 5'd0;
        v[b] = 1'b1;
        exp_vec[c] = v;
    endfunction

    logic [4:0] act, expv;
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            act  = {bus.ram_we, time_setup, dds_update, crc_err, frm_err};
            expv = exp_vec.exists(cyc) ? exp_vec[cyc] : 5'd0;
            check("pulses", 32'(act), 32'(expv));
            if (expv[4] && act[4]) begin
                check("ram_addr", 32'(bus.ram_addr), 32'(exp_addr[cyc]));
                check("ram_data", 32'(bus.ram_data), 32'(exp_data[cyc]));
            end
            if (expv[3])
                m_time = exp_time[cyc];
            check("time_regs", {dni, h, min, s}, m_time);
            if (bus.ram_we)
                ram_m[bus.ram_addr] = bus.ram_data;
            n_we  += int'(bus.ram_we);
            n_ts  += int'(time_setup);
            n_dds += int'(dds_update);
            n_crc += int'(crc_err);
            n_frm += int'(frm_err);
            if (exp_vec.exists(cyc))
                exp_vec.delete(cyc);
        end
    end

    // Planned byte stream: data, SOF flag and the edge at which the DUT samples it.
    logic [7:0] tx_d [$];
    logic       tx_s [$];
    int         tx_t [$];
    logic [7:0] frm_q [$];
    int next_stamp;

    task automatic begin_tx();
        tx_d.delete();
        tx_s.delete();
        tx_t.delete();
        next_stamp = cyc + 1;
    endtask

    task automatic plan(input logic [7:0] d, input logic sof, input int gap);
        next_stamp += gap;
        tx_d.push_back(d);
        tx_s.push_back(sof);
        tx_t.push_back(next_stamp);
        next_stamp++;
    endtask

    // Frame-level rules: type, length limits, 16-bit word sum, one status pulse per complete frame.
    task automatic model(input int s0, input int n);
        logic [7:0]  typ, len;
        logic [15:0] sum, w, crc;
        logic [31:0] tv;
        int hi;
        typ = tx_d[s0];
        if (typ != 8'h01 && typ != 8'h02) begin
            post(tx_t[s0], 0);
            return;
        end
        if (n < 2) return;
        len = tx_d[s0+1];
        if (len == 8'd0 || len > 8'd250 || (typ == 8'h01 && len != 8'd4)) begin
            post(tx_t[s0+1], 0);
            return;
        end
        sum = '0;
        tv  = '0;
        for (int k = 0; k < int'(len); k++) begin
            hi = 3 + 2 * k;
            if (hi >= n) break;
            w = {tx_d[s0+hi], tx_d[s0+hi-1]};
            sum += w;
            if (typ == 8'h02) begin
                post(tx_t[s0+hi], 4);
                exp_addr[tx_t[s0+hi]] = 8'(k);
                exp_data[tx_t[s0+hi]] = w;
            end else begin
                tv[31-8*k -: 8] = tx_d[s0+hi-1];
            end
        end
        hi = 3 + 2 * int'(len);
        if (hi >= n) return;
        crc = {tx_d[s0+hi], tx_d[s0+hi-1]};
        if (crc != sum) begin
            post(tx_t[s0+hi], 1);
        end else if (typ == 8'h01) begin
            post(tx_t[s0+hi], 3);
            exp_time[tx_t[s0+hi]] = tv;
        end else begin
            post(tx_t[s0+hi], 2);
        end
    endtask

    task automatic add_frame(input int gap, input int long_idx, input int long_gap);
        int s0;
        s0 = tx_d.size();
        for (int i = 0; i < frm_q.size(); i++)
            plan(frm_q[i], i == 0, (i == long_idx) ? long_gap : gap);
        model(s0, frm_q.size());
    endtask

    task automatic run_tx();
        for (int i = 0; i < tx_d.size(); i++) begin
            while (cyc + 1 < tx_t[i]) begin
                bus.in_valid = 1'b0;
                bus.in_sof   = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_data  = tx_d[i];
            bus.in_valid = 1'b1;
            bus.in_sof   = tx_s[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int b_we, b_ts, b_dds, b_crc, b_frm;
    task automatic snap();
        b_we = n_we; b_ts = n_ts; b_dds = n_dds; b_crc = n_crc; b_frm = n_frm;
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        idle(3);

        // Reset state
        check("rst_time", {dni, h, min, s}, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pulses", 32'({bus.ram_we, time_setup, dds_update, crc_err, frm_err}), 32'h0);
        check("rst_ram_bus", 32'({bus.ram_addr, bus.ram_data}), 32'h0);
        rst = 1'b0;
        chk_on = 1'b1;
        idle(2);

        // Good time frame
        snap();
        begin_tx();
        frm_q = '{8'h01, 8'h04, 8'h11, 8'h00, 8'h17, 8'h00, 8'h3B, 8'h00, 8'h2A, 8'h00, 8'h8D, 8'h00};
        add_frame(0, -1, 0);
        run_tx();
        idle(3);
        check("t1_time_lit", {dni, h, min, s}, 32'h11173B2A);
        check("t1_ts_cnt", 32'(n_ts - b_ts), 32'd1);
        check("t1_we_cnt", 32'(n_we - b_we), 32'd0);
        check("t1_busy", 32'(busy), 32'h0);

        // Good DDS frame, then the bad-CRC copy back-to-back
        snap();
        begin_tx();
        frm_q = '{8'h02, 8'h03, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'hFF, 8'h00, 8'hBE};
        add_frame(1, -1, 0);
        frm_q = '{8'h02, 8'h03, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'hFF, 8'h01, 8'hBE};
        add_frame(0, -1, 0);
        run_tx();
        idle(3);
        check("t2_ram0", 32'(ram_m[0]), 32'h1234);
        check("t2_ram1", 32'(ram_m[1]), 32'hABCD);
        check("t2_ram2", 32'(ram_m[2]), 32'hFFFF);
        check("t2_we_cnt", 32'(n_we - b_we), 32'd6);
        check("t2_dds_cnt", 32'(n_dds - b_dds), 32'd1);
        check("t3_crc_cnt", 32'(n_crc - b_crc), 32'd1);
        check("t3_time_kept", {dni, h, min, s}, 32'h11173B2A);

        // DDS frame aborted by a SOF carrying a full time frame
        snap();
        begin_tx();
        frm_q = '{8'h02, 8'h02, 8'h34, 8'h12};
        add_frame(0, -1, 0);
        frm_q = '{8'h01, 8'h04, 8'h11, 8'h00, 8'h17, 8'h00, 8'h3B, 8'h00, 8'h2A, 8'h00, 8'h8D, 8'h00};
        post(next_stamp, 0);
        add_frame(0, -1, 0);
        run_tx();
        idle(3);
        check("t4_frm_cnt", 32'(n_frm - b_frm), 32'd1);
        check("t4_we_cnt", 32'(n_we - b_we), 32'd1);
        check("t4_ts_cnt", 32'(n_ts - b_ts), 32'd1);
        check("t4_time_lit", {dni, h, min, s}, 32'h11173B2A);

        // Header and length rejects: bad type, LEN 0, LEN 251, TIME with LEN 3
        snap();
        begin_tx();
        frm_q = '{8'h03};       add_frame(0, -1, 0);
        frm_q = '{8'h02, 8'h00}; add_frame(1, -1, 0);
        frm_q = '{8'h02, 8'hFB}; add_frame(0, -1, 0);
        frm_q = '{8'h01, 8'h03}; add_frame(0, -1, 0);
        run_tx();
        idle(3);
        check("len_rej_cnt", 32'(n_frm - b_frm), 32'd4);
        check("len_rej_busy", 32'(busy), 32'h0);

        // Timeout after LEN, then a stray non-SOF byte
        snap();
        begin_tx();
        frm_q = '{8'h01, 8'h04};
        add_frame(0, -1, 0);
        post(tx_t[1] + TIMEOUT_CYC, 0);
        run_tx();
        check("tmo_busy_before", 32'(busy), 32'h1);
        idle(TIMEOUT_CYC + 4);
        check("tmo_frm_cnt", 32'(n_frm - b_frm), 32'd1);
        check("tmo_busy_after", 32'(busy), 32'h0);
        begin_tx();
        plan(8'h01, 1'b0, 0);
        run_tx();
        idle(3);
        check("stray_busy", 32'(busy), 32'h0);

        // Byte arriving on the timeout cycle wins
        snap();
        begin_tx();
        frm_q = '{8'h02, 8'h01, 8'hEF, 8'hBE, 8'hEF, 8'hBE};
        add_frame(0, 2, TIMEOUT_CYC - 1);
        run_tx();
        idle(3);
        check("tie_frm_cnt", 32'(n_frm - b_frm), 32'd0);
        check("tie_dds_cnt", 32'(n_dds - b_dds), 32'd1);
        check("tie_ram0", 32'(ram_m[0]), 32'hBEEF);

        // New committed time, then reset in the middle of another time frame
        begin_tx();
        frm_q = '{8'h01, 8'h04, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00, 8'h1A, 8'h00};
        add_frame(0, -1, 0);
        run_tx();
        idle(2);
        check("t6_time_lit", {dni, h, min, s}, 32'h05060708);
        begin_tx();
        frm_q = '{8'h01, 8'h04, 8'h11, 8'h00, 8'h17};
        add_frame(0, -1, 0);
        run_tx();
        chk_on = 1'b0;
        rst = 1'b1;
        exp_vec.delete();
        m_time = '0;
        #1;
        check("mid_rst_time", {dni, h, min, s}, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_out", 32'({bus.ram_we, bus.ram_addr, time_setup, dds_update, crc_err, frm_err}), 32'h0);
        idle(2);
        rst = 1'b0;
        chk_on = 1'b1;
        snap();
        idle(10);
        check("post_rst_pulses", 32'((n_ts - b_ts) + (n_frm - b_frm) + (n_crc - b_crc) + (n_dds - b_dds)), 32'd0);
        check("post_rst_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
